// File: rtl/addsub_pkg.sv
// Shared definitions for the adder/subtractor result path and its flag consumers.
package addsub_pkg;

  localparam int unsigned ADDSUB_WIDTH = 32;
  localparam int unsigned ADDSUB_TAGW  = 5;
  localparam int unsigned NFLAGS       = 5;

  // Bit positions inside the {E,N,Z,C,V} flag vector.
  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_E = 4;

  // One buffered result as seen by the register-file write port.
  typedef struct packed {
    logic [ADDSUB_WIDTH-1:0] data;
    logic [ADDSUB_TAGW-1:0]  rd;
    logic [NFLAGS-1:0]       flags;
  } result_entry_t;

endpackage

// File: rtl/addsub_flags.sv
// Condition flags and adder self-check for one add/subtract result.
module addsub_flags
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              sub,
  input  logic [WIDTH-1:0]  f,
  output logic [NFLAGS-1:0] flags_c
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   ref_sum;

  // Reference sum and flags; N/Z/V come from f so a faulty adder shows through.
  always_comb begin
    bx              = b ^ {WIDTH{sub}};
    ref_sum         = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(sub);
    flags_c         = '0;
    flags_c[FLAG_N] = f[WIDTH-1];
    flags_c[FLAG_Z] = (f == '0);
    flags_c[FLAG_C] = ref_sum[WIDTH];
    flags_c[FLAG_V] = (a[WIDTH-1] == bx[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
    flags_c[FLAG_E] = (f != ref_sum[WIDTH-1:0]);
  end

endmodule

// File: rtl/addsub_result_stage.sv
// Result stage: flags each adder result, buffers it in a small FIFO and
// tracks sticky overflow/mismatch status and a retired-result count.
module addsub_result_stage
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAGW  = ADDSUB_TAGW,
  parameter int unsigned CNTW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_sub,
  input  logic [WIDTH-1:0]  in_f,
  input  logic [TAGW-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAGW-1:0]   out_rd,
  output logic [NFLAGS-1:0] out_flags,
  output logic              sticky_v,
  output logic              sticky_e,
  input  logic              clr_sticky,
  output logic [CNTW-1:0]   retired
);

  localparam int unsigned PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTBW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] in_flags_c;
  result_entry_t     in_entry;
  result_entry_t     mem [DEPTH];
  result_entry_t     head_q, head_n;
  logic [PTRW-1:0]   wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CNTBW-1:0]  count, count_n;
  logic              in_ready_n, out_valid_n;
  logic              sticky_v_n, sticky_e_n;
  logic [CNTW-1:0]   retired_n;
  logic              push, pop;

  addsub_flags #(.WIDTH(WIDTH)) u_flags (
    .a       (in_a),
    .b       (in_b),
    .sub     (in_sub),
    .f       (in_f),
    .flags_c (in_flags_c)
  );

  assign in_entry  = '{data: in_f, rd: in_rd, flags: in_flags_c};
  assign out_data  = head_q.data;
  assign out_rd    = head_q.rd;
  assign out_flags = head_q.flags;

  // Next-state for pointers, occupancy, head register, sticky bits and counter.
  always_comb begin
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    count_n     = count;
    head_n      = head_q;
    retired_n   = retired;
    if (push) wr_ptr_n = wr_ptr + PTRW'(1);
    if (pop) begin
      rd_ptr_n  = rd_ptr + PTRW'(1);
      retired_n = retired + CNTW'(1);
    end
    if (push && !pop)      count_n = count + CNTBW'(1);
    else if (pop && !push) count_n = count - CNTBW'(1);
    // New head is either the slot being written this cycle or already stored.
    if (pop || (push && count == '0)) begin
      if (push && wr_ptr == rd_ptr_n) head_n = in_entry;
      else                            head_n = mem[rd_ptr_n];
    end
    in_ready_n  = (count_n != CNTBW'(DEPTH));
    out_valid_n = (count_n != '0);
    sticky_v_n  = (push && in_flags_c[FLAG_V]) || (sticky_v && !clr_sticky);
    sticky_e_n  = (push && in_flags_c[FLAG_E]) || (sticky_e && !clr_sticky);
  end

  // Control and head state; reset discards every buffered entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sticky_v  <= 1'b0;
      sticky_e  <= 1'b0;
      retired   <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      head_q    <= head_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      sticky_v  <= sticky_v_n;
      sticky_e  <= sticky_e_n;
      retired   <= retired_n;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Randomized and directed bench for addsub_result_stage against a queue model.
module tb_addsub_result_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic        sticky_v, sticky_e, clr_sticky;
  logic [31:0] in_a, in_b, in_f, out_data;
  logic [4:0]  in_rd, out_rd, out_flags;
  logic [15:0] retired;

  addsub_result_stage #(.WIDTH(32), .DEPTH(DEPTH), .TAGW(5), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_f(in_f), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_flags(out_flags), .sticky_v(sticky_v),
    .sticky_e(sticky_e), .clr_sticky(clr_sticky), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [4:0]  flags;
  } exp_t;

  exp_t        exp_q[$];
  logic        exp_sv, exp_se;
  int unsigned exp_retired;
  int          errors = 0;
  int          checks = 0;

  // Flags {E,N,Z,C,V} from arithmetic meaning of add/subtract.
  function automatic logic [4:0] model_flags(logic [31:0] a, logic [31:0] b,
                                             logic sub, logic [31:0] f);
    longint unsigned ua, ub;
    logic [31:0] exact;
    logic c, v, same_sign;
    ua = {32'd0, a};
    ub = {32'd0, b};
    exact = sub ? a - b : a + b;
    c = sub ? (ua >= ub) : ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
    same_sign = sub ? (a[31] != b[31]) : (a[31] == b[31]);
    v = same_sign && (f[31] != a[31]);
    return {f != exact, f[31], f == 32'd0, c, v};
  endfunction

  // Drive one cycle at a negedge, advance the model, return at next negedge.
  task automatic drive_cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input logic [31:0] f, input logic [4:0] rd,
                             input logic ordy, input logic clr, output logic accepted);
    logic do_pop;
    logic [4:0] fl;
    exp_t e;
    in_valid = iv; in_a = a; in_b = b; in_sub = sub; in_f = f; in_rd = rd;
    out_ready = ordy; clr_sticky = clr;
    accepted = iv && (exp_q.size() < DEPTH);
    do_pop   = ordy && (exp_q.size() > 0);
    fl = model_flags(a, b, sub, f);
    if (do_pop) begin
      void'(exp_q.pop_front());
      exp_retired = (exp_retired + 1) & 32'hFFFF;
    end
    if (accepted) begin
      e.data = f; e.rd = rd; e.flags = fl;
      exp_q.push_back(e);
    end
    exp_sv = (accepted && fl[0]) || (exp_sv && !clr);
    exp_se = (accepted && fl[4]) || (exp_se && !clr);
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_sv = 1'b0; exp_se = 1'b0; exp_retired = 0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_a = 0; in_b = 0; in_sub = 0; in_f = 0; in_rd = 0;
    out_ready = 0; clr_sticky = 0;
  endtask

  task automatic test_reset();
    logic acc;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL por_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL por_in_ready got %b want 1", in_ready); end
    checks++; if ({out_data, out_rd, out_flags} !== 42'd0) begin errors++; $display("FAIL por_head got %h/%h/%h want 0", out_data, out_rd, out_flags); end
    checks++; if ({sticky_v, sticky_e, retired} !== 18'd0) begin errors++; $display("FAIL por_status got %b%b %h want 0", sticky_v, sticky_e, retired); end
    rst_n = 1'b1;
    @(negedge clk);
    // Two held entries, one with overflow, then an asynchronous reset between edges.
    drive_cycle(1, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 5'd9, 0, 0, acc);
    drive_cycle(1, 32'h1, 32'h1, 0, 32'h3, 5'd10, 0, 0, acc);
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, acc);
    checks++; if (!(out_valid === 1'b1 && in_ready === 1'b1 && sticky_v === 1'b1 && retired === 16'd1))
      begin errors++; $display("FAIL pre_reset got v=%b r=%b sv=%b ret=%0d want 1 1 1 1", out_valid, in_ready, sticky_v, retired); end
    in_valid = 1'b1; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready got %b want 1", in_ready); end
    checks++; if ({sticky_v, sticky_e, retired} !== 18'd0) begin errors++; $display("FAIL async_status got %b%b %0d want 0", sticky_v, sticky_e, retired); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1, 32'd20, 32'd22, 0, 32'd42, 5'd17, 0, 0, acc);
    checks++; if (!(out_valid === 1'b1 && out_rd === 5'd17 && out_data === 32'd42))
      begin errors++; $display("FAIL post_reset_head got v=%b rd=%0d d=%0d want 1 17 42", out_valid, out_rd, out_data); end
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, acc);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_drain got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    logic acc;
    drive_cycle(1, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 5'd3, 1, 0, acc);
    checks++; if (!(out_valid === 1'b1 && out_data === 32'h8000_0000 && out_rd === 5'd3))
      begin errors++; $display("FAIL ovf_head got v=%b d=%h rd=%0d want 1 80000000 3", out_valid, out_data, out_rd); end
    checks++; if (out_flags !== 5'b01001) begin errors++; $display("FAIL ovf_flags got %b want 01001", out_flags); end
    checks++; if (sticky_v !== 1'b1) begin errors++; $display("FAIL ovf_sticky_v got %b want 1", sticky_v); end
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, acc);
  endtask

  task automatic test_sub();
    logic acc;
    int unsigned start;
    start = exp_retired;
    drive_cycle(1, 32'd5, 32'd5, 1, 32'd0, 5'd6, 1, 0, acc);
    checks++; if (!(out_valid === 1'b1 && out_flags === 5'b00110 && out_rd === 5'd6))
      begin errors++; $display("FAIL sub_eq got v=%b fl=%b rd=%0d want 1 00110 6", out_valid, out_flags, out_rd); end
    drive_cycle(1, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 5'd7, 1, 0, acc);
    checks++; if (!(out_valid === 1'b1 && out_flags === 5'b01000 && out_data === 32'hFFFF_FFFE))
      begin errors++; $display("FAIL sub_neg got v=%b fl=%b d=%h want 1 01000 fffffffe", out_valid, out_flags, out_data); end
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, acc);
    checks++; if (retired !== 16'((start + 2) & 32'hFFFF)) begin errors++; $display("FAIL sub_retired got %0d want %0d", retired, (start + 2) & 32'hFFFF); end
  endtask

  task automatic test_backpressure();
    logic acc;
    int idx;
    int unsigned start;
    logic [31:0] vals [3];
    vals[0] = 32'h1111; vals[1] = 32'h2222; vals[2] = 32'h3333;
    start = exp_retired;
    idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      drive_cycle(idx < 3, vals[idx % 3], 32'h0, 0, vals[idx % 3], 5'(20 + idx), cyc >= 6, 0, acc);
      if (acc) idx++;
      checks++; if (in_ready !== (exp_q.size() < DEPTH)) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_q.size() < DEPTH); end
      if (cyc >= 2 && cyc <= 5) begin
        checks++; if (!(in_ready === 1'b0 && out_rd === 5'd20 && out_data === 32'h1111))
          begin errors++; $display("FAIL bp_stall cyc %0d got r=%b rd=%0d d=%h want 0 20 1111", cyc, in_ready, out_rd, out_data); end
      end
      if (exp_q.size() != 0) begin
        checks++; if (!(out_valid === 1'b1 && out_rd === exp_q[0].rd && out_data === exp_q[0].data))
          begin errors++; $display("FAIL bp_order cyc %0d got v=%b rd=%0d want rd=%0d", cyc, out_valid, out_rd, exp_q[0].rd); end
      end
    end
    checks++; if (!(out_valid === 1'b0 && retired === 16'((start + 3) & 32'hFFFF)))
      begin errors++; $display("FAIL bp_done got v=%b ret=%0d want 0 %0d", out_valid, retired, (start + 3) & 32'hFFFF); end
  endtask

  task automatic test_mismatch();
    logic acc;
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 1, acc);
    checks++; if ({sticky_v, sticky_e} !== 2'b00) begin errors++; $display("FAIL mm_clear got %b%b want 00", sticky_v, sticky_e); end
    drive_cycle(1, 32'd1, 32'd1, 0, 32'd3, 5'd11, 1, 0, acc);
    checks++; if (!(out_flags === 5'b10000 && sticky_e === 1'b1 && sticky_v === 1'b0))
      begin errors++; $display("FAIL mm_flags got fl=%b se=%b sv=%b want 10000 1 0", out_flags, sticky_e, sticky_v); end
    drive_cycle(1, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 5'd12, 1, 1, acc);
    checks++; if ({sticky_v, sticky_e} !== 2'b10) begin errors++; $display("FAIL mm_set_wins got %b%b want 10", sticky_v, sticky_e); end
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, acc);
  endtask

  task automatic test_random();
    logic acc, sub, ordy, iv, clr;
    logic [31:0] a, b, f;
    for (int cyc = 0; cyc < 400; cyc++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) a = {a[31], 31'h7FFF_FFF0 | a[3:0]};
      f = sub ? a - b : a + b;
      if ($urandom_range(7, 0) == 0) f = f ^ (32'h1 << $urandom_range(31, 0));
      if ($urandom_range(15, 0) == 0) f = 32'd0;
      iv = 1'($urandom_range(3, 0) != 0);
      ordy = 1'($urandom_range(2, 0) != 0);
      clr = 1'($urandom_range(9, 0) == 0);
      drive_cycle(iv, a, b, sub, f, 5'($urandom), ordy, clr, acc);
      checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b", cyc, out_valid); end
      checks++; if (in_ready !== (exp_q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b", cyc, in_ready); end
      if (exp_q.size() != 0) begin
        checks++; if ({out_data, out_rd, out_flags} !== {exp_q[0].data, exp_q[0].rd, exp_q[0].flags})
          begin errors++; $display("FAIL rnd_head cyc %0d got %h/%0d/%b want %h/%0d/%b", cyc, out_data, out_rd, out_flags, exp_q[0].data, exp_q[0].rd, exp_q[0].flags); end
      end
      checks++; if ({sticky_v, sticky_e, retired} !== {exp_sv, exp_se, 16'(exp_retired)})
        begin errors++; $display("FAIL rnd_status cyc %0d got %b%b %0d want %b%b %0d", cyc, sticky_v, sticky_e, retired, exp_sv, exp_se, exp_retired); end
    end
    repeat (3) drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, acc);
  endtask

  task automatic test_wrap();
    logic acc;
    int bad;
    bad = 0;
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1, 32'd0, 32'd0, 0, 32'd0, 5'd0, 0, 0, acc);
    for (int i = 1; i <= 65538; i++) begin
      drive_cycle(1, 32'(i), 32'd1, 0, 32'(i + 1), 5'(i % 32), 1, 0, acc);
      if (!(out_valid === 1'b1 && in_ready === 1'b1 && out_rd === 5'(i % 32) && out_data === 32'(i + 1))) begin
        checks++; errors++; bad++;
        if (bad < 5) $display("FAIL wrap_step %0d got v=%b r=%b rd=%0d want 1 1 %0d", i, out_valid, in_ready, out_rd, i % 32);
      end
    end
    checks++; if (retired !== 16'd2) begin errors++; $display("FAIL wrap_retired got %0d want 2", retired); end
    checks++; if (!(out_valid === 1'b1 && exp_q.size() == 1)) begin errors++; $display("FAIL wrap_occupancy got v=%b", out_valid); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_sub();
    test_backpressure();
    test_mismatch();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
